// File: rtl/irda_sir_rx.sv
// rtl/irda_sir_rx.sv - IrDA SIR receive deframer
//
// Receives return-to-zero IrDA SIR frames from a demodulated IR receiver.
// The line is oversampled at 16 ticks per bit cell. A low pulse anywhere in
// a cell reads as bit 0 and a pulse-free cell reads as bit 1. Each frame has
// 10 cells: a start cell, 8 data cells sent LSB first, and a stop cell.
//
// Parameters:
//   DIV          clk cycles per oversample tick (1..1023)
//   SYNC_STAGES  depth of the input synchroniser (2..3)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   ir_in       IR receiver output, idles high
//   data_out    {frame_err, stop, byte}; holds its value until the next frame
//   data_valid  one-cycle strobe when data_out is updated
//   busy        high while a frame is being received
//
// Optional build macro IRDA_GLITCH_FILTER_EN: a low level counts only when it
// is seen on two consecutive ticks, and a start edge must still be low at the
// following tick before a frame begins.

module irda_sir_rx #(
   parameter int DIV         = 27,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ir_in,
   output logic [9:0] data_out,
   output logic       data_valid,
   output logic       busy
);

   localparam logic [9:0] DIV_LAST = 10'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ir_s;
   logic                   ir_s_prev;
   logic [9:0]             div_cnt;
   logic [3:0]             tick_cnt;
   logic [2:0]             bit_idx;
   logic                   pulse_seen;
   logic [7:0]             shreg;

   logic                   fall;
   logic                   tick;
   logic                   bit_val;
   logic                   low_hit;

`ifdef IRDA_GLITCH_FILTER_EN
   logic                   prev_low;   // ir_s was low at the previous tick
   logic                   cand;       // start edge seen, waiting for confirmation
`endif

   // Input synchroniser; idles high so reset does not fake a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= '1;
         ir_s_prev <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], ir_in};
         ir_s_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign ir_s    = sync_q[SYNC_STAGES-1];
   assign fall    = ir_s_prev & ~ir_s;
   assign tick    = (div_cnt == DIV_LAST);
   // Bit value of the cell that is ending; a pulse means 0.
   assign bit_val = ~pulse_seen;

`ifdef IRDA_GLITCH_FILTER_EN
   assign low_hit = ~ir_s & prev_low;
`else
   assign low_hit = ~ir_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         div_cnt    <= '0;
         tick_cnt   <= '0;
         bit_idx    <= '0;
         pulse_seen <= 1'b0;
         shreg      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
`ifdef IRDA_GLITCH_FILTER_EN
         prev_low   <= 1'b0;
         cand       <= 1'b0;
`endif
      end else begin
         data_valid <= 1'b0;

         // Divider free-runs; a start edge overrides it below to re-phase
         // the tick stream onto the incoming frame.
         if (tick) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 10'd1;
         end

`ifdef IRDA_GLITCH_FILTER_EN
         if (tick) begin
            prev_low <= ~ir_s;
         end
`endif

         case (state)
            IDLE: begin
`ifdef IRDA_GLITCH_FILTER_EN
               if (cand) begin
                  if (tick) begin
                     cand <= 1'b0;
                     if (!ir_s) begin
                        // Confirmed one tick after the edge, hence tick 5.
                        state      <= START;
                        busy       <= 1'b1;
                        tick_cnt   <= 4'd5;
                        bit_idx    <= '0;
                        pulse_seen <= 1'b1;
                     end
                  end
               end else if (fall) begin
                  cand    <= 1'b1;
                  div_cnt <= '0;
               end
`else
               if (fall) begin
                  // The pulse edge sits at tick 4 of the start cell, leaving
                  // margin for early and late pulses in later cells.
                  state      <= START;
                  busy       <= 1'b1;
                  div_cnt    <= '0;
                  tick_cnt   <= 4'd4;
                  bit_idx    <= '0;
                  pulse_seen <= 1'b1;
               end
`endif
            end

            default: begin
               if (tick) begin
                  if (tick_cnt == 4'd15) begin
                     // End of a cell: consume the bit and open a new cell.
                     tick_cnt   <= '0;
                     pulse_seen <= 1'b0;
                     case (state)
                        START: begin
                           state <= DATA;
                        end
                        DATA: begin
                           shreg   <= {bit_val, shreg[7:1]};
                           bit_idx <= bit_idx + 3'd1;
                           if (bit_idx == 3'd7) begin
                              state <= STOP;
                           end
                        end
                        default: begin
                           // Stop cell: a pulse here is a framing error,
                           // but the byte is still delivered.
                           state      <= IDLE;
                           busy       <= 1'b0;
                           data_out   <= {~bit_val, bit_val, shreg};
                           data_valid <= 1'b1;
                        end
                     endcase
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                     if (low_hit) begin
                        pulse_seen <= 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irda_sir_rx.sv
// tb/tb_irda_sir_rx.sv - scoreboard testbench for irda_sir_rx
module tb_irda_sir_rx;

   localparam int DIV  = 2;
   localparam int SS   = 2;
   localparam int CELL = 32;   // clk per bit cell at DIV=2
   localparam int PW   = 6;    // pulse width in clk

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       ir_in = 1'b1;
   logic [9:0] data_out;
   logic       data_valid;
   logic       busy;

   always #5 clk = ~clk;

   irda_sir_rx #(.DIV(DIV), .SYNC_STAGES(SS)) dut (
      .clk        (clk),
      .rst        (rst),
      .ir_in      (ir_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy)
   );

   int         checks   = 0;
   int         failures = 0;
   logic [9:0] exp_q[$];
   int         vt[$];
   int         cyc        = 0;
   int         busy_total = 0;
   logic       prev_v     = 1'b0;
   logic [9:0] exp_w;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe pops one expected word.
   always @(negedge clk) begin
      if (busy) busy_total = busy_total + 1;
      if (!rst && data_valid) begin
         vt.push_back(cyc);
         checks = checks + 1;
         if (prev_v) begin
            failures = failures + 1;
            $display("FAIL valid_width: data_valid high two cycles, required one");
         end
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL unexpected_valid: data_out=%h, required no strobe", data_out);
         end else begin
            exp_w = exp_q.pop_front();
            if (data_out !== exp_w) begin
               failures = failures + 1;
               $display("FAIL frame_word: data_out=%h required %h", data_out, exp_w);
            end
         end
      end
      prev_v = data_valid;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // Reference model: a pulse-free stop cell reads stop=1; a pulse there
   // flags a framing error and reads stop=0.
   function automatic logic [9:0] model_word(input logic [7:0] b, input bit stop_pulse);
      return {stop_pulse, ~stop_pulse, b};
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks = checks + 1;
      if (act != req) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         ir_in = 1'b1;
      end
   endtask

   // jmode: 0 nominal, 1 random offset of up to +/-3 ticks, 2 alternating +/-3 ticks.
   task automatic send(input logic [7:0] b, input bit stop_pulse, input int jmode, input int len_clk);
      int ps[10];
      int off;
      logic lvl;
      ps[0] = 0;
      for (int k = 1; k <= 8; k++) begin
         if (jmode == 1)      off = int'($urandom_range(0, 12)) - 6;
         else if (jmode == 2) off = (k % 2 == 1) ? 6 : -6;
         else                 off = 0;
         ps[k] = b[k-1] ? -1 : CELL * k + off;
      end
      ps[9] = stop_pulse ? CELL * 9 : -1;
      for (int t = 0; t < len_clk; t++) begin
         lvl = 1'b1;
         for (int k = 0; k < 10; k++)
            if (ps[k] >= 0 && t >= ps[k] && t < ps[k] + PW) lvl = 1'b0;
         @(negedge clk);
         ir_in = lvl;
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      int b0;
      int idx;
      logic [7:0] rb;
      bit rs;

      repeat (4) @(negedge clk);
      check("reset_data_out", int'(data_out), 0);
      check("reset_valid", int'(data_valid), 0);
      check("reset_busy", int'(busy), 0);
      rst = 1'b0;
      idle(20);

      // Clean 0xA5 frame.
      exp_q.push_back(model_word(8'hA5, 1'b0));
      b0 = busy_total;
      send(8'hA5, 1'b0, 0, 10 * CELL);
      idle(20);
      wait_drain(1000);
      check("busy_span_ok", int'((busy_total - b0) >= 300 && (busy_total - b0) <= 320), 1);
      idle(50);
      check("data_out_hold", int'(data_out), int'(10'h1A5));

      // Framing error: pulse in the stop cell.
      exp_q.push_back(model_word(8'hA5, 1'b1));
      send(8'hA5, 1'b1, 0, 10 * CELL);
      idle(20);
      wait_drain(1000);

      // Back-to-back frames.
      idx = vt.size();
      exp_q.push_back(model_word(8'h3C, 1'b0));
      exp_q.push_back(model_word(8'hFF, 1'b0));
      send(8'h3C, 1'b0, 0, 10 * CELL);
      send(8'hFF, 1'b0, 0, 10 * CELL);
      idle(20);
      wait_drain(1000);
      if (vt.size() >= idx + 2) check("b2b_spacing", vt[idx+1] - vt[idx], 10 * CELL);
      else check("b2b_strobes", vt.size() - idx, 2);

      // 0x00 with +/-3 tick jitter on every data pulse.
      exp_q.push_back(model_word(8'h00, 1'b0));
      send(8'h00, 1'b0, 2, 10 * CELL);
      idle(20);
      wait_drain(1000);

      // Two-clk glitch on an idle line.
      b0 = busy_total;
`ifndef IRDA_GLITCH_FILTER_EN
      exp_q.push_back(model_word(8'hFF, 1'b0));
`endif
      repeat (2) begin
         @(negedge clk);
         ir_in = 1'b0;
      end
      idle(10 * CELL + 20);
      wait_drain(1000);
`ifdef IRDA_GLITCH_FILTER_EN
      check("glitch_busy_cycles", busy_total - b0, 0);
`endif

      // Randomised frames with jitter, stop errors and random gaps.
      for (int i = 0; i < 10; i++) begin
         rb = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 3) == 0);
         exp_q.push_back(model_word(rb, rs));
         send(rb, rs, 1, 10 * CELL);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 30)));
      end
      idle(20);
      wait_drain(1000);

      // Reset during bit 4 discards the frame.
      send(8'h5A, 1'b0, 0, 5 * CELL + 16);
      @(negedge clk);
      rst   = 1'b1;
      ir_in = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_data_out", int'(data_out), 0);
      check("midreset_busy", int'(busy), 0);
      idle(12 * CELL);
      check("midreset_no_frame", exp_q.size(), 0);
      exp_q.push_back(model_word(8'h5A, 1'b0));
      send(8'h5A, 1'b0, 0, 10 * CELL);
      idle(20);
      wait_drain(1000);
      check("final_data_out", int'(data_out), int'(10'h15A));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
